ntt_bitrev_loader: RTL

NTT_BITREV_LOADER -- requirements
Module: ntt_bitrev_loader

---
 rtl/ntt_bitrev_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ntt_bitrev_loader.sv
// Purpose : serial-to-parallel loader that stores one N-point frame in
//           bit-reversed order (reduced mod MODULUS) for NTT stage 1.
// Latency : out_valid rises the cycle after the 16th accepted sample.
// Backpressure: in_ready is low while a frame is held. The frame stays
//           stable until out_ready; the handoff cycle accepts nothing.
//
// Ports:
//   clk, rst           - single clock, synchronous active-high reset
//   in_data/in_valid/in_ready    - serial coefficients, natural order
//   dout0..dout15/out_valid/out_ready - registered parallel frame
//   frame_cnt          - frames delivered, wraps modulo 256
module ntt_bitrev_loader #(
   parameter int N          = 16,   // only 16 is supported
   parameter int DATA_WIDTH = 16,
   parameter int MODULUS    = 17
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] dout0,
   output logic [DATA_WIDTH-1:0] dout1,
   output logic [DATA_WIDTH-1:0] dout2,
   output logic [DATA_WIDTH-1:0] dout3,
   output logic [DATA_WIDTH-1:0] dout4,
   output logic [DATA_WIDTH-1:0] dout5,
   output logic [DATA_WIDTH-1:0] dout6,
   output logic [DATA_WIDTH-1:0] dout7,
   output logic [DATA_WIDTH-1:0] dout8,
   output logic [DATA_WIDTH-1:0] dout9,
   output logic [DATA_WIDTH-1:0] dout10,
   output logic [DATA_WIDTH-1:0] dout11,
   output logic [DATA_WIDTH-1:0] dout12,
   output logic [DATA_WIDTH-1:0] dout13,
   output logic [DATA_WIDTH-1:0] dout14,
   output logic [DATA_WIDTH-1:0] dout15,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            frame_cnt
);

   localparam int KW = $clog2(N);
   localparam logic [KW-1:0]         K_LAST = KW'(N - 1);
   localparam logic [DATA_WIDTH-1:0] MOD_W  = DATA_WIDTH'(MODULUS);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [KW-1:0]         k;
   logic [DATA_WIDTH-1:0] coef [N];
   logic [DATA_WIDTH-1:0] reduced;
   logic                  accept;
   logic                  deliver;

   function automatic logic [KW-1:0] bitrev(input logic [KW-1:0] x);
      logic [KW-1:0] r;
      r = '0;
      for (int i = 0; i < KW; i++) begin
         r[i] = x[KW-1-i];
      end
      return r;
   endfunction

   // Constant divisor, so this reduces to a fixed remainder network.
   assign reduced = in_data % MOD_W;
   assign accept  = in_valid & in_ready;
   assign deliver = out_valid & out_ready;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         FILL: begin
            // Gated by rst so nothing looks accepted during a reset cycle.
            in_ready = ~rst;
            if (in_valid && (k == K_LAST)) begin
               state_nxt = FULL;
            end
         end
         FULL: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         k         <= '0;
         frame_cnt <= '0;
         for (int i = 0; i < N; i++) begin
            coef[i] <= '0;
         end
      end else begin
         state <= state_nxt;
         if (accept) begin
            coef[bitrev(k)] <= reduced;
            // Wraps from N-1 to 0 exactly on the FILL-to-FULL edge.
            k <= k + KW'(1);
         end
         if (deliver) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   assign dout0  = coef[0];
   assign dout1  = coef[1];
   assign dout2  = coef[2];
   assign dout3  = coef[3];
   assign dout4  = coef[4];
   assign dout5  = coef[5];
   assign dout6  = coef[6];
   assign dout7  = coef[7];
   assign dout8  = coef[8];
   assign dout9  = coef[9];
   assign dout10 = coef[10];
   assign dout11 = coef[11];
   assign dout12 = coef[12];
   assign dout13 = coef[13];
   assign dout14 = coef[14];
   assign dout15 = coef[15];

endmodule
